muldiv_execute_unit: RTL



---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_iter_step.sv | 42 ++++
 rtl/muldiv_execute_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared decode constants and FSM encoding for the i16 mul/div execute unit.
// Imported by the control unit and by the execute unit.
package muldiv_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_IMM_W = 5;

    localparam logic ALU_MUL = 1'b0;
    localparam logic ALU_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
// acc is the product / partial remainder, a the multiplicand / dividend-quotient.
module muldiv_iter_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] a_n,
    output logic [WIDTH-1:0] b_n
);

    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;

    assign sh   = {acc, a[WIDTH-1]};
    assign diff = sh - {1'b0, b};

    always_comb begin
        acc_n = acc;
        a_n   = a;
        b_n   = b;
        unique case (op)
            ALU_MUL: begin
                acc_n = acc + (b[0] ? a : '0);
                a_n   = a << 1;
                b_n   = b >> 1;
            end
            ALU_DIV: begin
                // negative trial difference means restore
                acc_n = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
                a_n   = {a[WIDTH-2:0], ~diff[WIDTH]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_execute_unit.sv
// Iterative MUL/DIV plus LUI execute unit between decode and writeback.
// Valid/ready handshake on both sides; one instruction in flight.
module muldiv_execute_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMM_W = DEF_IMM_W,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             LoadUpperImmediate,
    input  logic             ALUOpcode,
    input  logic             UseImmediate,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [IMM_W-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, opa, opb;
    logic [WIDTH-1:0] acc_n, opa_n, opb_n;
    logic [WIDTH-1:0] opb_in, lui_val, res_q;
    logic             dbz_q, accept, last, zdiv, busy;

    assign opb_in  = UseImmediate ? {{(WIDTH-IMM_W){1'b0}}, imm} : rt_data;
    assign lui_val = {imm, {(WIDTH-IMM_W){1'b0}}};
    assign zdiv    = (ALUOpcode == ALU_DIV) && (opb_in == '0);
    assign accept  = in_valid & in_ready;
    assign last    = cnt == CNT_W'(1);
    assign busy    = (state == MUL) || (state == DIV);

    assign in_ready    = state == IDLE;
    assign out_valid   = state == DONE;
    assign result      = res_q;
    assign div_by_zero = dbz_q;

    muldiv_iter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .op   (state == DIV),
        .acc  (acc),
        .a    (opa),
        .b    (opb),
        .acc_n(acc_n),
        .a_n  (opa_n),
        .b_n  (opb_n)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (LoadUpperImmediate)      state_n = DONE;
                    else if (zdiv)               state_n = DONE;
                    else if (ALUOpcode == ALU_DIV) state_n = DIV;
                    else                         state_n = MUL;
                end
            end
            MUL, DIV: if (last) state_n = DONE;
            DONE:     if (out_ready) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
            res_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt   <= CNT_W'(WIDTH);
                acc   <= '0;
                opa   <= rs_data;
                opb   <= opb_in;
                dbz_q <= !LoadUpperImmediate && zdiv;
                if (LoadUpperImmediate) res_q <= lui_val;
                else if (zdiv)          res_q <= '1;
            end else if (busy) begin
                cnt <= cnt - CNT_W'(1);
                acc <= acc_n;
                opa <= opa_n;
                opb <= opb_n;
                // quotient ends in opa, product in acc
                if (last) res_q <= (state == DIV) ? opa_n : acc_n;
            end
        end
    end

endmodule
